// File: rtl/vector_lane_sequencer_pkg.sv
// vlane_pkg: PE opcodes, SEW codes and sequencer FSM encoding
// shared by the vector lane sequencer, its counter and the bench.
package vlane_pkg;

    localparam logic [7:0] VADD_VV  = 8'h00;
    localparam logic [7:0] VMUL_VV  = 8'h01;
    localparam logic [7:0] VDOT_VV  = 8'h02;
    localparam logic [7:0] VADDVARP = 8'h03;
    localparam logic [7:0] VMULVARP = 8'h04;
    localparam logic [7:0] VDOTVARP = 8'h05;

    localparam logic [9:0] SEW_8  = 10'd8;
    localparam logic [9:0] SEW_16 = 10'd16;
    localparam logic [9:0] SEW_32 = 10'd32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        WB    = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/vector_lane_sequencer_if.sv
// Command channel of the vector lane sequencer (valid/ready).
// master = issuer, slave = sequencer. Ports: cmd_valid, cmd_ready, cmd_instr/vd/vs1/vs2/vl/sew.
interface vector_lane_sequencer_if #(
    parameter int VL_W = 6
);
    import vlane_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    logic [7:0]      cmd_instr;
    logic [4:0]      cmd_vd;
    logic [4:0]      cmd_vs1;
    logic [4:0]      cmd_vs2;
    logic [VL_W-1:0] cmd_vl;
    logic [9:0]      cmd_sew;

    modport master (
        output cmd_valid, cmd_instr, cmd_vd, cmd_vs1,
        output cmd_vs2, cmd_vl, cmd_sew,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_instr, cmd_vd, cmd_vs1,
        input  cmd_vs2, cmd_vl, cmd_sew,
        output cmd_ready
    );

endinterface

// File: rtl/vector_lane_sequencer_elem_counter.sv
// vlane_elem_counter: element index with clear, increment and last flag.
// Ports: clk, reset, clr, inc, vl (length), idx (index), last (idx == vl-1).
module vlane_elem_counter
    import vlane_pkg::*;
#(
    parameter int VL_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    input  logic [VL_W-1:0] vl,
    output logic [4:0]      idx,
    output logic            last
);

    // Wide enough for idx+1 and vl without wrap.
    localparam int CW = (VL_W > 5) ? VL_W + 1 : 6;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 5'd1;
        end
    end

    assign last = ((CW'(idx) + CW'(1)) == CW'(vl));

endmodule

// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer: walks vl elements through RF read, PE issue, wait, write-back.
// Ports: clk, reset, cmd (slave if), rf read/write, PE start/done, busy, cmd_done;
// perf_busy_cycles only when VLANE_SEQ_PERF_EN is defined.
module vector_lane_sequencer
    import vlane_pkg::*;
#(
    parameter int VLEN_WORDS = 32,
    parameter int VL_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    vector_lane_sequencer_if.slave cmd,
    output logic        rf_rd_en,
    output logic [4:0]  rf_ra_reg,
    output logic [4:0]  rf_rb_reg,
    output logic [4:0]  rf_ra_idx,
    output logic [4:0]  rf_rb_idx,
    input  logic [31:0] rf_rdata_a,
    input  logic [31:0] rf_rdata_b,
    output logic        pe_start,
    output logic [7:0]  pe_instruction,
    output logic [31:0] pe_opA,
    output logic [31:0] pe_opB,
    output logic [31:0] pe_opC,
    output logic [9:0]  pe_sew,
    input  logic        pe_done,
    input  logic [31:0] pe_peout,
    output logic        rf_we,
    output logic [4:0]  rf_wa_reg,
    output logic [4:0]  rf_wa_idx,
    output logic [31:0] rf_wdata,
    output logic        busy,
    output logic        cmd_done
`ifdef VLANE_SEQ_PERF_EN
    ,
    output logic [31:0] perf_busy_cycles
`endif
);

    localparam logic [VL_W-1:0] VL_MAX = VL_W'(VLEN_WORDS);

    seq_state_t      state, nstate;
    logic [7:0]      instr_q;
    logic [4:0]      vd_q, vs1_q, vs2_q;
    logic [VL_W-1:0] vl_q;
    logic [9:0]      sew_q;
    logic [31:0]     result_q;
    logic [VL_W-1:0] vl_in;
    logic            accept;
    logic [4:0]      idx;
    logic            last;

    // Oversized lengths are clamped before they are latched.
    assign vl_in  = (cmd.cmd_vl > VL_MAX) ? VL_MAX : cmd.cmd_vl;
    assign accept = (state == IDLE) && cmd.cmd_valid;

    vlane_elem_counter #(
        .VL_W (VL_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .inc   ((state == WB) && !last),
        .vl    (vl_q),
        .idx   (idx),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            instr_q  <= '0;
            vd_q     <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vl_q     <= '0;
            sew_q    <= '0;
            result_q <= '0;
        end else begin
            state <= nstate;
            if (accept) begin
                instr_q <= cmd.cmd_instr;
                vd_q    <= cmd.cmd_vd;
                vs1_q   <= cmd.cmd_vs1;
                vs2_q   <= cmd.cmd_vs2;
                vl_q    <= vl_in;
                sew_q   <= cmd.cmd_sew;
            end
            // WAIT exits on the first done, so this captures only once.
            if ((state == WAIT) && pe_done) begin
                result_q <= pe_peout;
            end
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (cmd.cmd_valid) nstate = (vl_in == '0) ? DONE : READ;
            READ:    nstate = ISSUE;
            ISSUE:   nstate = WAIT;
            WAIT:    if (pe_done) nstate = WB;
            WB:      nstate = last ? DONE : READ;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign cmd_done      = (state == DONE);

    always_comb begin
        rf_rd_en       = 1'b0;
        rf_ra_reg      = '0;
        rf_rb_reg      = '0;
        rf_ra_idx      = '0;
        rf_rb_idx      = '0;
        pe_start       = 1'b0;
        pe_instruction = '0;
        pe_sew         = '0;
        pe_opA         = '0;
        pe_opB         = '0;
        pe_opC         = '0;
        rf_we          = 1'b0;
        rf_wa_reg      = '0;
        rf_wa_idx      = '0;
        rf_wdata       = '0;
        unique case (state)
            READ: begin
                rf_rd_en  = 1'b1;
                rf_ra_reg = vs1_q;
                rf_rb_reg = vs2_q;
                rf_ra_idx = idx;
                rf_rb_idx = idx;
            end
            ISSUE: begin
                pe_start       = 1'b1;
                pe_instruction = instr_q;
                pe_sew         = sew_q;
                pe_opA         = rf_rdata_a;
                pe_opB         = rf_rdata_b;
            end
            WAIT: begin
                pe_instruction = instr_q;
                pe_sew         = sew_q;
            end
            WB: begin
                rf_we     = 1'b1;
                rf_wa_reg = vd_q;
                rf_wa_idx = idx;
                rf_wdata  = result_q;
            end
            default: ;
        endcase
    end

`ifdef VLANE_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_busy_cycles <= '0;
        end else if (busy) begin
            perf_busy_cycles <= perf_busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed bench for vector_lane_sequencer with RF and PE models.
// Cycle 0 is the cycle cmd_valid is presented in IDLE.
module tb_vector_lane_sequencer;
    import vlane_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vector_lane_sequencer_if #(.VL_W(6)) cif();

    logic        rf_rd_en;
    logic [4:0]  rf_ra_reg, rf_rb_reg, rf_ra_idx, rf_rb_idx;
    logic [31:0] rf_rdata_a = '0;
    logic [31:0] rf_rdata_b = '0;
    logic        pe_start;
    logic [7:0]  pe_instruction;
    logic [31:0] pe_opA, pe_opB, pe_opC;
    logic [9:0]  pe_sew;
    logic        pe_done = 1'b1;
    logic [31:0] pe_peout = '0;
    logic        rf_we;
    logic [4:0]  rf_wa_reg, rf_wa_idx;
    logic [31:0] rf_wdata;
    logic        busy, cmd_done;
`ifdef VLANE_SEQ_PERF_EN
    logic [31:0] perf_busy_cycles;
`endif

    vector_lane_sequencer #(
        .VLEN_WORDS (32),
        .VL_W       (6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd            (cif),
        .rf_rd_en       (rf_rd_en),
        .rf_ra_reg      (rf_ra_reg),
        .rf_rb_reg      (rf_rb_reg),
        .rf_ra_idx      (rf_ra_idx),
        .rf_rb_idx      (rf_rb_idx),
        .rf_rdata_a     (rf_rdata_a),
        .rf_rdata_b     (rf_rdata_b),
        .pe_start       (pe_start),
        .pe_instruction (pe_instruction),
        .pe_opA         (pe_opA),
        .pe_opB         (pe_opB),
        .pe_opC         (pe_opC),
        .pe_sew         (pe_sew),
        .pe_done        (pe_done),
        .pe_peout       (pe_peout),
        .rf_we          (rf_we),
        .rf_wa_reg      (rf_wa_reg),
        .rf_wa_idx      (rf_wa_idx),
        .rf_wdata       (rf_wdata),
        .busy           (busy),
        .cmd_done       (cmd_done)
`ifdef VLANE_SEQ_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles)
`endif
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    bit mon_on = 1'b0;
    int pe_delay = 0;
    int hold = 0;

    logic [31:0] a_val = '0;
    logic [31:0] b_val = '0;
    logic [7:0]  x_instr = '0;
    logic [9:0]  x_sew = '0;
    logic [4:0]  x_vs1 = '0;
    logic [4:0]  x_vs2 = '0;

    int rd_n, st_n, wr_n, done_n, done_cyc, rdy_cyc, err_n;
    int          wr_cyc[64];
    logic [31:0] wr_dat[64];
    logic [4:0]  wr_idx[64];
    logic [4:0]  wr_reg[64];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pe_fn(input logic [7:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        r = a + b;
        if (op == VADDVARP) begin
            for (int i = 0; i < 4; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
        end
        return r;
    endfunction

    // RF: data for a READ cycle is presented through the following cycle.
    always @(negedge clk) begin
        if (rf_rd_en) begin
            rf_rdata_a = a_val;
            rf_rdata_b = b_val;
        end
    end

    // PE: done stays low for pe_delay WAIT cycles after the start.
    always @(negedge clk) begin
        if (pe_start) begin
            pe_peout = pe_fn(pe_instruction, pe_opA, pe_opB);
            hold = pe_delay + 1;
        end else if (hold > 0) begin
            hold = hold - 1;
        end
        pe_done = (hold == 0);
    end

    always @(negedge clk) begin
        if (!mon_on) begin
            rd_n = 0; st_n = 0; wr_n = 0; done_n = 0;
            done_cyc = -1; rdy_cyc = -1; err_n = 0;
        end else begin
            if (rf_rd_en) begin
                if (rf_ra_reg != x_vs1 || rf_rb_reg != x_vs2 ||
                    rf_ra_idx != 5'(rd_n) || rf_rb_idx != 5'(rd_n))
                    err_n++;
                rd_n++;
            end
            if (pe_start) begin
                if (pe_instruction != x_instr || pe_sew != x_sew ||
                    pe_opA != a_val || pe_opB != b_val || pe_opC != 0)
                    err_n++;
                st_n++;
            end
            if (32'(rf_rd_en) + 32'(pe_start) + 32'(rf_we) > 1) err_n++;
            if (busy == cif.cmd_ready) err_n++;
            if (rf_we && wr_n < 64) begin
                wr_cyc[wr_n] = cyc - t0;
                wr_dat[wr_n] = rf_wdata;
                wr_idx[wr_n] = rf_wa_idx;
                wr_reg[wr_n] = rf_wa_reg;
                wr_n++;
            end
            if (cmd_done) begin
                done_n++;
                done_cyc = cyc - t0;
            end
            if (cif.cmd_ready && done_n > 0 && rdy_cyc < 0) rdy_cyc = cyc - t0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic issue(input logic [7:0] ins, input logic [4:0] vd,
                         input logic [4:0] vs1, input logic [4:0] vs2,
                         input logic [5:0] vl);
        @(negedge clk);
        mon_on = 1'b0;
        @(negedge clk);
        x_instr = ins; x_sew = SEW_32; x_vs1 = vs1; x_vs2 = vs2;
        cif.cmd_valid = 1'b1;
        cif.cmd_instr = ins;
        cif.cmd_vd = vd;
        cif.cmd_vs1 = vs1;
        cif.cmd_vs2 = vs2;
        cif.cmd_vl = vl;
        cif.cmd_sew = SEW_32;
        t0 = cyc;
        mon_on = 1'b1;
        @(negedge clk);
        cif.cmd_valid = 1'b0;
    endtask

    task automatic run(input logic [7:0] ins, input logic [4:0] vd,
                       input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic [5:0] vl, input int budget);
        issue(ins, vd, vs1, vs2, vl);
        for (int i = 0; i < budget && done_n == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_instr = '0;
        cif.cmd_vd = '0;
        cif.cmd_vs1 = '0;
        cif.cmd_vs2 = '0;
        cif.cmd_vl = '0;
        cif.cmd_sew = '0;

        do_reset();
        @(negedge clk);
        chk("rst_ready", 32'(cif.cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", {29'b0, rf_rd_en, pe_start, rf_we}, 0);
        chk("rst_done", 32'(cmd_done), 0);
        chk("rst_wdata", rf_wdata, 0);

        // single element add
        a_val = 32'h5; b_val = 32'h3;
        run(VADD_VV, 5'd3, 5'd1, 5'd2, 6'd1, 40);
        chk("t1_nwr", wr_n, 1);
        chk("t1_wcyc", wr_cyc[0], 4);
        chk("t1_wdata", wr_dat[0], 32'h8);
        chk("t1_wreg", 32'(wr_reg[0]), 3);
        chk("t1_widx", 32'(wr_idx[0]), 0);
        chk("t1_done", done_cyc, 5);
        chk("t1_rdy", rdy_cyc, 6);
        chk("t1_err", err_n, 0);

        // four elements, packed 8-bit lane add
        a_val = 32'h01020304; b_val = 32'h10101010;
        run(VADDVARP, 5'd7, 5'd4, 5'd5, 6'd4, 60);
        chk("t2_nwr", wr_n, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_wcyc%0d", k), wr_cyc[k], 4 * k + 4);
            chk($sformatf("t2_widx%0d", k), 32'(wr_idx[k]), k);
            chk($sformatf("t2_wdat%0d", k), wr_dat[k], 32'h11121314);
        end
        chk("t2_done", done_cyc, 17);
        chk("t2_err", err_n, 0);

        // zero length
        run(VADD_VV, 5'd1, 5'd1, 5'd1, 6'd0, 20);
        chk("t3_nrd", rd_n, 0);
        chk("t3_nst", st_n, 0);
        chk("t3_nwr", wr_n, 0);
        chk("t3_done", done_cyc, 1);
        chk("t3_rdy", rdy_cyc, 2);

        // PE stalls three cycles
        pe_delay = 3;
        a_val = 32'h7; b_val = 32'h9;
        run(VADD_VV, 5'd2, 5'd8, 5'd9, 6'd1, 40);
        chk("t4_wcyc", wr_cyc[0], 7);
        chk("t4_wdata", wr_dat[0], 32'h10);
        chk("t4_done", done_cyc, 8);
        chk("t4_rdy", rdy_cyc, 9);
        chk("t4_err", err_n, 0);
        pe_delay = 0;

        // length clamped to 32
        a_val = 32'h100; b_val = 32'h23;
        run(VADD_VV, 5'd10, 5'd11, 5'd12, 6'd40, 300);
        chk("t5_nwr", wr_n, 32);
        chk("t5_lastidx", 32'(wr_idx[31]), 31);
        chk("t5_lastcyc", wr_cyc[31], 128);
        chk("t5_done", done_cyc, 129);
        chk("t5_ndone", done_n, 1);
        chk("t5_err", err_n, 0);

        // reset after the second write aborts the command
        issue(VADD_VV, 5'd10, 5'd11, 5'd12, 6'd40);
        for (int i = 0; i < 40 && wr_n < 2; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rdy", 32'(cif.cmd_ready), 1);
        chk("t6_busy", 32'(busy), 0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_nwr", wr_n, 2);
        chk("t6_ndone", done_n, 0);

`ifdef VLANE_SEQ_PERF_EN
        mon_on = 1'b0;
        do_reset();
        a_val = 32'h1; b_val = 32'h2;
        run(VADD_VV, 5'd1, 5'd2, 5'd3, 6'd2, 60);
        chk("perf", perf_busy_cycles, 9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_lane_sequencer.md
VECTOR_LANE_SEQUENCER -- requirements
Module: vector_lane_sequencer

Interface
REQ-001 SHALL have parameter VLEN_WORDS, default 32: maximum 32-bit words per vector register.
REQ-002 SHALL have parameter VL_W, default 6: width of cmd_vl.
REQ-003 SHALL have ports clk, in, 1, the single clock; reset, in, 1, synchronous active-high reset.
REQ-004 SHALL have command ports: cmd_valid, in, 1; cmd_ready, out, 1; cmd_instr, in, 8 (PE opcode); cmd_vd/cmd_vs1/cmd_vs2, in, 5 each; cmd_vl, in, VL_W (word count); cmd_sew, in, 10.
REQ-005 SHALL have register-file read ports: rf_rd_en, out, 1; rf_ra_reg/rf_rb_reg, out, 5; rf_ra_idx/rf_rb_idx, out, 5; rf_rdata_a/rf_rdata_b, in, 32, valid one cycle after rf_rd_en.
REQ-006 SHALL have PE ports: pe_start, out, 1; pe_instruction, out, 8; pe_opA/pe_opB/pe_opC, out, 32; pe_sew, out, 10; pe_done, in, 1; pe_peout, in, 32.
REQ-007 SHALL have write-back ports: rf_we, out, 1; rf_wa_reg, out, 5; rf_wa_idx, out, 5; rf_wdata, out, 32.
REQ-008 SHALL have status ports: busy, out, 1; cmd_done, out, 1 (one-cycle pulse).

Function
REQ-009 SHALL implement FSM states IDLE, READ, ISSUE, WAIT, WB, DONE.
REQ-010 IDLE: cmd_ready=1; cmd_valid&&cmd_ready latches instr/vd/vs1/vs2/vl/sew, clears element index; next state READ, or DONE if latched vl==0.
REQ-011 cmd_vl > VLEN_WORDS SHALL be clamped to VLEN_WORDS at latch time.
REQ-012 READ: rf_rd_en=1, ra={vs1,idx}, rb={vs2,idx}; next ISSUE.
REQ-013 ISSUE: pe_start=1; pe_opA=rf_rdata_a, pe_opB=rf_rdata_b, pe_opC=0, pe_instruction/pe_sew = latched values held through WAIT; next WAIT.
REQ-014 WAIT: pe_peout captured into result register in the first cycle pe_done=1; stays in WAIT while pe_done=0; next WB.
REQ-015 WB: rf_we=1, rf_wa_reg=vd, rf_wa_idx=idx, rf_wdata=result; next READ with idx+1 if idx<vl-1, else DONE.
REQ-016 DONE: cmd_done=1 for exactly one cycle; next IDLE.
REQ-017 Timing with pe_done already high, accept cycle=0: element k written at cycle 4k+4; cmd_done at 4*vl+1; cmd_ready high at 4*vl+2; vl=0 gives cmd_done at cycle 1.
REQ-018 busy SHALL be 1 in every state except IDLE; cmd_ready SHALL be 0 whenever busy=1; cmd_valid while busy ignored.
REQ-019 Opcodes SHALL pass through unchecked; sequencer is opcode-agnostic.
REQ-020 rf_rd_en, pe_start, rf_we SHALL each be 1 only in their single state; all outputs registered or decoded from state only.

Reset
REQ-021 reset SHALL force IDLE, clear idx and latched command, result register to 0; all outputs 0 except cmd_ready=1.
REQ-022 reset mid-command SHALL abort it: no further rf_we and no cmd_done for that command.

Configuration
REQ-023 Macro VLANE_SEQ_PERF_EN: when defined, SHALL add output perf_busy_cycles, 32, counting cycles with busy=1 since reset, wrapping at 2^32, cleared by reset; when undefined the port and counter SHALL be absent and behaviour otherwise identical.

Structure
REQ-024 Shared package vlane_pkg SHALL hold PE opcode constants (VADD_VV=8'h00, VMUL_VV=8'h01, VDOT_VV=8'h02, VADDVARP=8'h03, VMULVARP=8'h04, VDOTVARP=8'h05), SEW codes (8, 16, 32), and the FSM state encoding.
REQ-025 Sub-module vlane_elem_counter SHALL hold the element index with clear, increment and last-element (idx==vl-1) flag.

Verification
REQ-026 reset, cmd vl=1, vs1 word0=0x00000005, vs2 word0=0x00000003, instr 00, sew 32, PE model returns sum -> rf_we at cycle 4, wdata 0x00000008, cmd_done at cycle 5.
REQ-027 vl=4, instr 03, PE model 8-bit lane add, operands 0x01020304 and 0x10101010 -> four writes idx 0..3 at cycles 4,8,12,16, each wdata 0x11121314; cmd_done at cycle 17.
REQ-028 vl=0 -> no rf_rd_en, no pe_start, no rf_we; cmd_done at cycle 1; cmd_ready at cycle 2.
REQ-029 PE model holds pe_done=0 for 3 cycles after pe_start -> WAIT extends 3 cycles; the element write and all later events shift by 3.
REQ-030 vl=40 with VLEN_WORDS=32 -> exactly 32 writes; reset asserted after the 2nd write -> no 3rd write, no cmd_done, cmd_ready=1 next cycle.
REQ-031 With VLANE_SEQ_PERF_EN defined, vl=2 from reset -> perf_busy_cycles=9 after return to IDLE.
